// File: rtl/cnn_layer_sched_if.sv
// Host/register and cnn_ctrl-facing signal bundle of the layer scheduler.
// The scheduler uses the slave modport; the host or bench uses master.
interface cnn_layer_sched_if #(
    parameter int W_SIZE       = 12,
    parameter int W_FRAME_SIZE = 2*W_SIZE+1,
    parameter int W_DELAY      = 12,
    parameter int W_LAYER      = 3
);
    logic                    i_cfg_we;
    logic [W_LAYER-1:0]      i_cfg_addr;
    logic [W_SIZE-1:0]       i_cfg_width;
    logic [W_SIZE-1:0]       i_cfg_height;
    logic [W_DELAY-1:0]      i_cfg_vdelay;
    logic [W_DELAY-1:0]      i_cfg_hdelay;
    logic [W_LAYER:0]        i_num_layers;
    logic [W_DELAY-1:0]      i_gap;
    logic                    i_run;
    logic                    i_abort;
    logic                    i_ctrl_data_run;
    logic                    i_end_frame;
    logic [W_SIZE-1:0]       o_width;
    logic [W_SIZE-1:0]       o_height;
    logic [W_DELAY-1:0]      o_vsync_delay;
    logic [W_DELAY-1:0]      o_hsync_delay;
    logic [W_FRAME_SIZE-1:0] o_frame_size;
    logic                    o_start;
    logic [W_LAYER-1:0]      o_layer_idx;
    logic                    o_busy;
    logic                    o_layer_done;
    logic                    o_all_done;
    logic                    o_cfg_err;

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_width, i_cfg_height, i_cfg_vdelay,
               i_cfg_hdelay, i_num_layers, i_gap, i_run, i_abort,
               i_ctrl_data_run, i_end_frame,
        output o_width, o_height, o_vsync_delay, o_hsync_delay, o_frame_size,
               o_start, o_layer_idx, o_busy, o_layer_done, o_all_done, o_cfg_err
    );

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_width, i_cfg_height, i_cfg_vdelay,
               i_cfg_hdelay, i_num_layers, i_gap, i_run, i_abort,
               i_ctrl_data_run, i_end_frame,
        input  o_width, o_height, o_vsync_delay, o_hsync_delay, o_frame_size,
               o_start, o_layer_idx, o_busy, o_layer_done, o_all_done, o_cfg_err
    );
endinterface

// File: rtl/cnn_layer_sched.sv
// Steps cnn_ctrl through a programmed table of layer geometries, one frame
// per layer, with a programmable idle gap between layers.
module cnn_layer_sched #(
    parameter int W_SIZE       = 12,
    parameter int W_FRAME_SIZE = 2*W_SIZE+1,
    parameter int W_DELAY      = 12,
    parameter int NUM_LAYERS   = 8,
    parameter int W_LAYER      = 3
) (
    input  logic               clk,
    input  logic               rst,
    cnn_layer_sched_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP, S_DONE} state_t;

    typedef struct packed {
        logic [W_SIZE-1:0]  width;
        logic [W_SIZE-1:0]  height;
        logic [W_DELAY-1:0] vdelay;
        logic [W_DELAY-1:0] hdelay;
    } entry_t;

    state_t                  state_q, state_d;
    entry_t                  table_q [NUM_LAYERS];
    entry_t                  rd_entry, wr_entry;
    logic [W_LAYER-1:0]      layer_idx_q;
    logic [W_LAYER:0]        num_layers_q;
    logic [W_DELAY-1:0]      gap_q, gap_cnt_q;
    logic                    abort_pend_q, cfg_err_q;
    logic [W_SIZE-1:0]       width_q, height_q;
    logic [W_DELAY-1:0]      vdelay_q, hdelay_q;
    logic [W_FRAME_SIZE-1:0] frame_size_q;
    logic                    run_empty, run_bad, entry_bad, last_layer, frame_end;

    assign wr_entry   = '{width: bus.i_cfg_width, height: bus.i_cfg_height,
                          vdelay: bus.i_cfg_vdelay, hdelay: bus.i_cfg_hdelay};
    assign rd_entry   = table_q[layer_idx_q];
    assign run_empty  = (bus.i_num_layers == '0);
    assign run_bad    = (bus.i_num_layers > (W_LAYER+1)'(NUM_LAYERS));
    assign entry_bad  = (rd_entry.width == '0) || (rd_entry.height == '0);
    assign last_layer = (({1'b0, layer_idx_q} + (W_LAYER+1)'(1)) >= num_layers_q);
    assign frame_end  = bus.i_ctrl_data_run && bus.i_end_frame;

    // Table only changes while idle so a running sequence sees stable geometry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) table_q[i] <= '0;
        end else if (bus.i_cfg_we && state_q == S_IDLE) begin
            table_q[bus.i_cfg_addr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_run) state_d = (run_empty || run_bad) ? S_DONE : S_LOAD;
            S_LOAD:  state_d = (bus.i_abort || entry_bad) ? S_DONE : S_START;
            S_START: state_d = bus.i_abort ? S_DONE : S_WAIT;
            S_WAIT:  if (frame_end) state_d = S_GAP;
            // A pending abort from WAIT cuts the gap to its first cycle.
            S_GAP: begin
                if (bus.i_abort || abort_pend_q)  state_d = S_DONE;
                else if (gap_cnt_q == gap_q)      state_d = last_layer ? S_DONE : S_LOAD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_start      = 1'b0;
        bus.o_layer_done = 1'b0;
        bus.o_all_done   = 1'b0;
        bus.o_busy       = (state_q != S_IDLE);
        case (state_q)
            S_START: bus.o_start      = 1'b1;
            S_GAP:   bus.o_layer_done = (gap_cnt_q == '0);
            S_DONE:  bus.o_all_done   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_idx_q  <= '0;
            num_layers_q <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            vdelay_q     <= '0;
            hdelay_q     <= '0;
            frame_size_q <= '0;
        end else begin
            gap_cnt_q <= (state_q == S_GAP) ? gap_cnt_q + 1'b1 : '0;
            case (state_q)
                S_IDLE: begin
                    abort_pend_q <= 1'b0;
                    if (bus.i_run && run_bad) begin
                        cfg_err_q <= 1'b1;
                    end else if (bus.i_run && !run_empty) begin
                        num_layers_q <= bus.i_num_layers;
                        gap_q        <= bus.i_gap;
                        cfg_err_q    <= 1'b0;
                        layer_idx_q  <= '0;
                    end
                end
                S_LOAD: begin
                    width_q      <= rd_entry.width;
                    height_q     <= rd_entry.height;
                    vdelay_q     <= rd_entry.vdelay;
                    hdelay_q     <= rd_entry.hdelay;
                    frame_size_q <= W_FRAME_SIZE'(rd_entry.width) * W_FRAME_SIZE'(rd_entry.height);
                    abort_pend_q <= 1'b0;
                    if (entry_bad) cfg_err_q <= 1'b1;
                end
                S_WAIT:  if (bus.i_abort) abort_pend_q <= 1'b1;
                S_GAP:   if (state_d == S_LOAD) layer_idx_q <= layer_idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.o_width       = width_q;
    assign bus.o_height      = height_q;
    assign bus.o_vsync_delay = vdelay_q;
    assign bus.o_hsync_delay = hdelay_q;
    assign bus.o_frame_size  = frame_size_q;
    assign bus.o_layer_idx   = layer_idx_q;
    assign bus.o_cfg_err     = cfg_err_q;
endmodule

// File: doc/cnn_layer_sched.md
Name: cnn_layer_sched

Overview:
- Layer scheduler that sequences the CNN frame timing controller (cnn_ctrl) through a programmed list of layer geometries.
- Holds a small per-layer configuration table and drives cnn_ctrl's q_width, q_height, q_vsync_delay, q_hsync_delay, q_frame_size and q_start.
- Waits for each frame to complete, inserts an inter-layer gap, then advances to the next layer.
- Sits between the host/register interface and cnn_ctrl.

Parameters:
- W_SIZE, 12, width/height field width; matches cnn_ctrl.
- W_FRAME_SIZE, 2*W_SIZE+1, frame size field width.
- W_DELAY, 12, vsync/hsync delay and gap counter width.
- NUM_LAYERS, 8, configuration table depth.
- W_LAYER, 3, layer index width (clog2 NUM_LAYERS).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- i_cfg_we  in  1  table write strobe.
- i_cfg_addr  in  W_LAYER  table entry written.
- i_cfg_width  in  W_SIZE  layer width.
- i_cfg_height  in  W_SIZE  layer height.
- i_cfg_vdelay  in  W_DELAY  layer vsync delay.
- i_cfg_hdelay  in  W_DELAY  layer hsync delay.
- i_num_layers  in  W_LAYER+1  number of layers to run; sampled on run.
- i_gap  in  W_DELAY  inter-layer gap; sampled on run.
- i_run  in  1  start sequence (level sampled in IDLE).
- i_abort  in  1  graceful stop request.
- i_ctrl_data_run  in  1  from cnn_ctrl o_ctrl_data_run.
- i_end_frame  in  1  from cnn_ctrl o_end_frame.
- o_width  out  W_SIZE  to q_width.
- o_height  out  W_SIZE  to q_height.
- o_vsync_delay  out  W_DELAY  to q_vsync_delay.
- o_hsync_delay  out  W_DELAY  to q_hsync_delay.
- o_frame_size  out  W_FRAME_SIZE  to q_frame_size.
- o_start  out  1  to q_start; one-cycle pulse.
- o_layer_idx  out  W_LAYER  current layer.
- o_busy  out  1  high in every state except IDLE.
- o_layer_done  out  1  one-cycle pulse per completed frame.
- o_all_done  out  1  one-cycle pulse at end of sequence.
- o_cfg_err  out  1  sticky configuration error.

Behaviour:
- Reset: all outputs 0, state IDLE, table entries 0, captured num_layers/gap 0.
- Table writes: accepted only in IDLE; ignored while o_busy.
- States: IDLE, LOAD, START, WAIT, GAP, DONE.
- IDLE, i_run=1:
  - i_num_layers==0 -> DONE; no o_start.
  - i_num_layers>NUM_LAYERS -> set o_cfg_err, go to DONE.
  - Otherwise capture num_layers and gap, clear o_cfg_err, layer_idx=0, go to LOAD.
- LOAD (1 cycle): register table[layer_idx] onto the o_* config outputs; o_frame_size=width*height (full W_FRAME_SIZE product, no truncation).
  - width==0 or height==0 -> set o_cfg_err, go to DONE with no start for this layer.
  - Otherwise go to START.
- START (1 cycle): o_start=1 -> WAIT.
- Latency: i_run at cycle 0 -> o_start high in cycle 2; config outputs valid from cycle 2.
- WAIT: frame complete on the cycle where i_ctrl_data_run && i_end_frame -> GAP.
  - Config outputs are held stable from LOAD until leaving WAIT.
- GAP: o_layer_done=1 in its first cycle. Counter starts at 0; leave when counter==gap.
  - Duration is gap+1 cycles.
  - Exit to LOAD with layer_idx+1 if layers remain and no abort pending; else DONE.
  - Completion at cycle T with gap=0 -> next o_start at T+3.
- DONE (1 cycle): o_all_done=1 -> IDLE. o_busy drops in IDLE.
- Abort: i_abort in LOAD/START/GAP -> DONE next cycle.
  - If in START, the o_start of that cycle still issues; the frame is then not tracked.
  - i_abort in WAIT sets a pending flag; the current frame finishes, GAP is skipped, o_layer_done still pulses in a 1-cycle GAP, then DONE.
- Config outputs retain their last values in IDLE/DONE.
- o_cfg_err stays set until the next accepted i_run.
- i_run while busy is ignored.
- Reset mid-operation: immediate return to reset values. cnn_ctrl must be reset together with this block.

Test Plan:
- Two-layer run: table[0]=4x2 (vdelay 1, hdelay 1), table[1]=3x3; num_layers=2, gap=2, cnn_ctrl instanced.
  - Frame sizes 8 then 9.
  - Exactly two o_start pulses, layer_idx 0 then 1.
  - Two o_layer_done pulses; o_all_done one cycle after the second GAP ends.
  - Second o_start 5 cycles after the first frame's completion cycle.
- num_layers=0 -> o_busy high 1 cycle, o_all_done pulse, no o_start, o_cfg_err=0.
- num_layers=9 -> o_cfg_err=1, o_all_done pulse, no o_start. Next valid run clears o_cfg_err.
- table[1] width=0, num_layers=3 -> layer 0 completes; o_cfg_err=1, o_all_done pulse, only 1 o_start.
- i_abort during layer 0 WAIT of a 3-layer run -> frame 0 completes, o_layer_done, o_all_done, no second o_start.
- Table write and i_run while busy are ignored (table readback via next run unchanged).
- rst asserted in WAIT -> all outputs 0 asynchronously; a fresh run then works normally.
